// File: rtl/csa_accum_resolver.sv
// Carry-save multi-operand accumulator: compresses one operand per beat into a
// redundant sum/carry pair, then resolves it chunk by chunk into a binary total.
module csa_accum_resolver #(
    parameter int DATA_W  = 4,
    parameter int ACC_W   = 12,
    parameter int CHUNK_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              busy
);

    localparam int NCH = ACC_W / CHUNK_W;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

    typedef enum logic [1:0] {
        S_ACC,
        S_RESOLVE,
        S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   s_q, s_d;
    logic [ACC_W-1:0]   c_q, c_d;
    logic [ACC_W-1:0]   res_q, res_d;
    logic               ovf_q, ovf_d;
    logic               ovf_out_q, ovf_out_d;
    logic               rc_q, rc_d;
    logic [KW-1:0]      k_q, k_d;

    logic [ACC_W-1:0]   x;
    logic [ACC_W-1:0]   maj;
    logic [CHUNK_W:0]   csum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_ACC;
            s_q       <= '0;
            c_q       <= '0;
            res_q     <= '0;
            ovf_q     <= 1'b0;
            ovf_out_q <= 1'b0;
            rc_q      <= 1'b0;
            k_q       <= '0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            c_q       <= c_d;
            res_q     <= res_d;
            ovf_q     <= ovf_d;
            ovf_out_q <= ovf_out_d;
            rc_q      <= rc_d;
            k_q       <= k_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        c_d       = c_q;
        res_d     = res_q;
        ovf_d     = ovf_q;
        ovf_out_d = ovf_out_q;
        rc_d      = rc_q;
        k_d       = k_q;
        x         = ACC_W'(in_data);
        maj       = (s_q & c_q) | (s_q & x) | (c_q & x);
        csum      = {1'b0, s_q[k_q*CHUNK_W +: CHUNK_W]}
                  + {1'b0, c_q[k_q*CHUNK_W +: CHUNK_W]}
                  + (CHUNK_W+1)'(rc_q);

        case (state_q)
            S_ACC: begin
                if (in_valid) begin
                    s_d = s_q ^ c_q ^ x;
                    c_d = maj << 1;
                    // A majority bit shifted out of the top is a carry worth 2^ACC_W.
                    if (maj[ACC_W-1]) ovf_d = 1'b1;
                    if (in_last) begin
                        state_d = S_RESOLVE;
                        k_d     = '0;
                        rc_d    = 1'b0;
                    end
                end
            end
            S_RESOLVE: begin
                res_d[k_q*CHUNK_W +: CHUNK_W] = csum[CHUNK_W-1:0];
                rc_d = csum[CHUNK_W];
                k_d  = KW'(k_q + 1'b1);
                if (k_q == K_LAST) begin
                    ovf_d     = ovf_q | csum[CHUNK_W];
                    ovf_out_d = ovf_q | csum[CHUNK_W];
                    state_d   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    s_d       = '0;
                    c_d       = '0;
                    res_d     = '0;
                    ovf_d     = 1'b0;
                    ovf_out_d = 1'b0;
                    rc_d      = 1'b0;
                    state_d   = S_ACC;
                end
            end
            default: state_d = S_ACC;
        endcase
    end

    assign in_ready  = (state_q == S_ACC);
    assign busy      = (state_q != S_ACC);
    assign out_valid = (state_q == S_HOLD);
    assign out_sum   = res_q;
    assign out_ovf   = ovf_out_q;

endmodule

// File: doc/csa_accum_resolver.md
# csa_accum_resolver

Streaming multi-operand accumulator that is the consumer end of the team's carry-save adder path. Operands arrive one per beat over a valid/ready handshake and are compressed into a redundant sum/carry register pair with a 3:2 carry-save stage, so no carry propagates during accumulation. On the frame's last beat the block resolves the redundant pair into a binary total with a chunked carry-propagate adder. It then presents the result, with an exact overflow flag, on an output handshake.

## Interface
- DATA_W, 4, operand width
- ACC_W, 12, accumulator/result width; must be ≥ DATA_W and an integer multiple of CHUNK_W
- CHUNK_W, 4, bits resolved per cycle; NCH = ACC_W/CHUNK_W
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts a beat
- in_data  input  DATA_W  unsigned operand, zero-extended to ACC_W
- in_last  input  1  beat is the last of the frame
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out_sum  output  ACC_W  frame total modulo 2^ACC_W
- out_ovf  output  1  true frame total ≥ 2^ACC_W
- busy  output  1  high in RESOLVE or HOLD

## Operation
- State machine:
  - ACC: in_ready=1. On accept (in_valid&in_ready), zero-extend in_data to x.
  - Compress: s' = s^c^x; m = maj(s,c,x); c' = m<<1, truncated to ACC_W.
  - If m[ACC_W-1]=1, set sticky ovf.
  - in_last=0 on accept: stay in ACC. in_last=1 on accept: go to RESOLVE with k=0 and rc=0.
- RESOLVE: in_ready=0. Each cycle, chunk k of s plus chunk k of c plus rc gives result chunk k and new rc. k increments.
  - After chunk NCH-1, ovf |= rc, then go to HOLD.
- HOLD: out_valid=1, in_ready=0. out_sum and out_ovf are stable.
  - On out_valid&out_ready: clear s, c, ovf, the result and rc, then go to ACC.
- Every frame contains at least one beat, because in_last travels with data.
- ovf is exact: the true total equals s+c plus 2^ACC_W times the dropped carries. Any dropped carry or a final rc=1 means the total is ≥ 2^ACC_W.
- in_valid outside ACC is ignored. in_data and in_last are don't-care when not accepted.
- The output is fully registered. out_sum holds the result while out_valid=1 and is otherwise don't-care.

## Timing
- Reset (async, immediate): state=ACC, s=c=0, ovf=0, out_valid=0, out_sum=0, out_ovf=0, busy=0, in_ready=1.
- Throughput in ACC: one beat per cycle, with no bubbles between non-last beats.
- Latency: the last beat is accepted at edge T. RESOLVE runs on edges T+1..T+NCH. out_valid is high after edge T+NCH (3 cycles for the defaults).
- Result accepted at edge H: out_valid=0 and in_ready=1 after edge H. The first beat of the next frame can be accepted at edge H+1.
- Minimum frame period is 1 + NCH + 1 cycles.
- in_ready and busy decode directly from registered state, with no combinational path from in_valid or out_ready.
- Reset asserted mid-RESOLVE or mid-HOLD aborts the frame. The partial result is discarded, and the next frame starts from zero.

## Test plan
- Defaults; one beat in_data=4'hF with in_last=1 -> out_valid 3 cycles after accept; out_sum=12'h00F, out_ovf=0.
- Frame 1,2,3,4 back-to-back, last on the 4th -> out_sum=10, out_ovf=0; in_ready=0 from the cycle after the last accept until the out handshake.
- Overflow boundary:
  - 273 beats of 4'hF -> out_sum=4095, ovf=0.
  - 274 beats -> out_sum=14, ovf=1.
  - Repeat with random in_valid gaps -> identical results.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD while driving in_valid=1 -> out_valid, out_sum and out_ovf stable, in_ready=0, no beat consumed. Release -> one handshake, then in_ready=1.
- Reset mid-RESOLVE: assert rst one cycle after accepting the last of frame 7,7 -> all outputs at reset values at once. The next frame of the single beat 5 gives out_sum=5, ovf=0.
- Back-to-back frames, then a random scoreboard:
  - Frames 15 then 1 -> results 15 then 1, with no residue from the previous frame.
  - 500 random frames of 1–300 beats against a reference model computing sum mod 4096 and the sum≥4096 flag.
